// File: rtl/vending_core_param_if.sv
// vending_core_param_if
//   Bundles every non-clock signal of vending_core_param.
//
//   Signalling: every *_valid / cancel / clear_sales input is a single-cycle
//   pulse sampled on the rising clock edge. Nothing back-pressures it; there
//   is no ready. Output pulses (coin_reject, dispense_valid, change_valid)
//   are high for exactly one cycle. Their data fields (dispense_code,
//   change_amount) are meaningful while the pulse is high and hold their
//   last value otherwise.
//
//   master : the coin/product-code decoder side. It drives the requests and
//            reads the status.
//   slave  : the vending core.
//
//   Requests : coin_valid/coin_value, sel_valid/sel_code, cancel,
//              restock_valid/restock_code, clear_sales, price_table.
//   Status   : credit, coin_reject, dispense_valid/dispense_code,
//              change_valid/change_amount, alarm, sales_total, state.
interface vending_core_param_if #(
  parameter int N_SLOTS = 4,
  parameter int VAL_W   = 8,
  parameter int TOTAL_W = 16
);
  localparam int SW = $clog2(N_SLOTS);

  logic                     coin_valid;
  logic [VAL_W-1:0]         coin_value;
  logic                     sel_valid;
  logic [SW-1:0]            sel_code;
  logic                     cancel;
  logic                     restock_valid;
  logic [SW-1:0]            restock_code;
  logic                     clear_sales;
  logic [N_SLOTS*VAL_W-1:0] price_table;

  logic [VAL_W-1:0]         credit;
  logic                     coin_reject;
  logic                     dispense_valid;
  logic [SW-1:0]            dispense_code;
  logic                     change_valid;
  logic [VAL_W-1:0]         change_amount;
  logic                     alarm;
  logic [TOTAL_W-1:0]       sales_total;
  logic [1:0]               state;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_code, cancel,
           restock_valid, restock_code, clear_sales, price_table,
    input  credit, coin_reject, dispense_valid, dispense_code,
           change_valid, change_amount, alarm, sales_total, state
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_code, cancel,
           restock_valid, restock_code, clear_sales, price_table,
    output credit, coin_reject, dispense_valid, dispense_code,
           change_valid, change_amount, alarm, sales_total, state
  );
endinterface

// File: rtl/vending_core_param.sv
// vending_core_param
//   Multi-slot vending controller. It accumulates coin credit and keeps a
//   stock counter per slot. A selection with enough credit and stock vends
//   the product and pays back any change. Cancel or an inactivity timeout
//   refunds the credit. It also keeps a saturating sales total.
//
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : vending_core_param_if.slave (requests in, status out)
//
//   FSM (bus.state): IDLE=0, COLLECT=1, VEND=2, PAYOUT=3. All outputs are
//   registered.
module vending_core_param #(
  parameter int N_SLOTS     = 4,
  parameter int VAL_W       = 8,
  parameter int STOCK_W     = 4,
  parameter int TOTAL_W     = 16,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vending_core_param_if.slave   bus
);

  localparam int SW = $clog2(N_SLOTS);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_PAYOUT  = 2'd3
  } state_t;

  state_t               state_q;
  logic [VAL_W-1:0]     credit_q;
  logic [VAL_W-1:0]     price_q;
  logic [SW-1:0]        slot_q;
  logic                 coin_reject_q;
  logic                 dispense_valid_q;
  logic [SW-1:0]        dispense_code_q;
  logic                 change_valid_q;
  logic [VAL_W-1:0]     change_amount_q;
  logic                 alarm_q;
  logic [TOTAL_W-1:0]   sales_total_q;
  logic [TW-1:0]        timer_q;
  logic [STOCK_W-1:0]   stock_q [N_SLOTS];

  // Unpack the flat price table so that a slot code can index it directly.
  logic [VAL_W-1:0]     price_arr [N_SLOTS];

  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      price_arr[k] = bus.price_table[k*VAL_W +: VAL_W];
    end
  end

  // Coin fits only if the sum does not carry out of VAL_W bits.
  logic [VAL_W:0]       coin_sum_d;
  logic                 coin_ok;
  logic [VAL_W-1:0]     sel_price;
  logic                 sel_ok;
  logic [VAL_W-1:0]     credit_after_vend_d;
  logic [TOTAL_W:0]     total_sum;
  logic [TOTAL_W-1:0]   sales_total_d;
  logic                 timed_out;

  assign coin_sum_d          = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok             = bus.coin_valid && !coin_sum_d[VAL_W];
  assign sel_price           = price_arr[bus.sel_code];
  assign sel_ok              = (stock_q[bus.sel_code] != '0) && (credit_q >= sel_price);
  assign credit_after_vend_d = credit_q - price_q;
  assign total_sum           = {1'b0, sales_total_q} + {{(TOTAL_W+1-VAL_W){1'b0}}, price_q};
  assign sales_total_d       = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
  // The counter restarts at 0 on each accepted coin. It therefore holds
  // TIMEOUT_CYC-1 in the last COLLECT cycle before the refund.
  assign timed_out           = (timer_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      credit_q         <= '0;
      price_q          <= '0;
      slot_q           <= '0;
      coin_reject_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_code_q  <= '0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
      alarm_q          <= 1'b0;
      sales_total_q    <= '0;
      timer_q          <= '0;
      for (int k = 0; k < N_SLOTS; k++) begin
        stock_q[k] <= '1;
      end
    end else begin
      coin_reject_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      change_valid_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (coin_ok) begin
            credit_q <= coin_sum_d[VAL_W-1:0];
            alarm_q  <= 1'b0;
            timer_q  <= '0;
            state_q  <= S_COLLECT;
          end else begin
            coin_reject_q <= bus.coin_valid;
            if (bus.sel_valid) begin
              alarm_q <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (bus.cancel) begin
            // Full refund. A coin in the same cycle loses to the cancel.
            alarm_q        <= 1'b0;
            coin_reject_q  <= bus.coin_valid;
            change_valid_q <= (credit_q != '0);
            if (credit_q != '0) begin
              change_amount_q <= credit_q;
            end
            state_q <= S_PAYOUT;
          end else if (bus.sel_valid && sel_ok) begin
            coin_reject_q    <= bus.coin_valid;
            slot_q           <= bus.sel_code;
            price_q          <= sel_price;
            dispense_valid_q <= 1'b1;
            dispense_code_q  <= bus.sel_code;
            state_q          <= S_VEND;
          end else if (!bus.sel_valid && coin_ok) begin
            credit_q <= coin_sum_d[VAL_W-1:0];
            alarm_q  <= 1'b0;
            timer_q  <= '0;
          end else begin
            // No accepted coin this cycle. This covers a failed selection,
            // a rejected coin, or no activity at all.
            if (bus.sel_valid) begin
              alarm_q <= 1'b1;
            end
            coin_reject_q <= bus.coin_valid;
            if (timed_out) begin
              change_valid_q <= (credit_q != '0);
              if (credit_q != '0) begin
                change_amount_q <= credit_q;
              end
              state_q <= S_PAYOUT;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end

        S_VEND: begin
          coin_reject_q     <= bus.coin_valid;
          credit_q          <= credit_after_vend_d;
          stock_q[slot_q]   <= stock_q[slot_q] - STOCK_W'(1);
          sales_total_q     <= sales_total_d;
          change_valid_q    <= (credit_after_vend_d != '0);
          if (credit_after_vend_d != '0) begin
            change_amount_q <= credit_after_vend_d;
          end
          state_q <= S_PAYOUT;
        end

        S_PAYOUT: begin
          coin_reject_q <= bus.coin_valid;
          credit_q      <= '0;
          state_q       <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // These assignments come after the case on purpose. Restock overrides
      // a VEND decrement of the same slot, and clear overrides a VEND add.
      if (bus.restock_valid) begin
        stock_q[bus.restock_code] <= '1;
      end
      if (bus.clear_sales) begin
        sales_total_q <= '0;
      end
    end
  end

  assign bus.credit         = credit_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_code  = dispense_code_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_amount  = change_amount_q;
  assign bus.alarm          = alarm_q;
  assign bus.sales_total    = sales_total_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_vending_core_param.sv
// tb_vending_core_param
//   Directed bench for vending_core_param with default parameters. Prices
//   are slot0=0, slot1=25, slot2=10 and slot3=200.
module tb_vending_core_param;

  localparam int N_SLOTS = 4;
  localparam int VAL_W   = 8;
  localparam int TOTAL_W = 16;
  localparam int TMO     = 30;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_total;

  vending_core_param_if #(.N_SLOTS(N_SLOTS), .VAL_W(VAL_W), .TOTAL_W(TOTAL_W)) bus ();

  vending_core_param #(
    .N_SLOTS(N_SLOTS), .VAL_W(VAL_W), .STOCK_W(4), .TOTAL_W(TOTAL_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic             coin_v;
    logic [VAL_W-1:0] coin;
    logic             sel_v;
    logic [1:0]       sel;
    logic             cancel;
    logic [VAL_W-1:0] e_credit;
    logic             e_rej;
    logic             e_disp;
    logic [1:0]       e_code;
    logic             e_chg;
    logic [VAL_W-1:0] e_amt;
    logic             e_alarm;
    logic [15:0]      e_total;
    logic [1:0]       e_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic cv, input logic [7:0] c, input logic sv, input logic [1:0] s, input logic cn,
    input logic [7:0] ecr, input logic erj, input logic eds, input logic [1:0] ecd,
    input logic ech, input logic [7:0] eam, input logic eal, input logic [15:0] etot,
    input logic [1:0] est);
    vec_t v;
    v.coin_v = cv; v.coin = c; v.sel_v = sv; v.sel = s; v.cancel = cn;
    v.e_credit = ecr; v.e_rej = erj; v.e_disp = eds; v.e_code = ecd;
    v.e_chg = ech; v.e_amt = eam; v.e_alarm = eal; v.e_total = etot; v.e_state = est;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [7:0] c, input logic sv,
                       input logic [1:0] s, input logic cn);
    bus.coin_valid = cv;
    bus.coin_value = c;
    bus.sel_valid  = sv;
    bus.sel_code   = s;
    bus.cancel     = cn;
    tick();
    bus.coin_valid = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.cancel     = 1'b0;
  endtask

  // Pay exactly the price and buy one unit, which must succeed.
  task automatic vend_ok(input logic [1:0] slot, input logic [7:0] price, input string tag);
    drive(1'b1, price, 1'b0, 2'd0, 1'b0);
    chk({tag, " credit"}, bus.credit, price);
    drive(1'b0, 8'd0, 1'b1, slot, 1'b0);
    chk({tag, " dispense_valid"}, bus.dispense_valid, 1);
    chk({tag, " dispense_code"}, bus.dispense_code, slot);
    tick();
    exp_total = exp_total + price;
    chk({tag, " sales_total"}, bus.sales_total, exp_total);
    chk({tag, " no change"}, bus.change_valid, 0);
    tick();
    chk({tag, " idle"}, bus.state, 0);
  endtask

  // Pay and select a sold-out slot. Credit stays in COLLECT afterwards.
  task automatic vend_sold_out(input logic [1:0] slot, input logic [7:0] price, input string tag);
    drive(1'b1, price, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, slot, 1'b0);
    chk({tag, " dispense_valid"}, bus.dispense_valid, 0);
    chk({tag, " alarm"}, bus.alarm, 1);
    chk({tag, " state"}, bus.state, 1);
  endtask

  task automatic refund(input logic [7:0] amt, input string tag);
    drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b1);
    chk({tag, " change_valid"}, bus.change_valid, 1);
    chk({tag, " change_amount"}, bus.change_amount, amt);
    tick();
    chk({tag, " idle"}, bus.state, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int seen;
    logic [7:0] seen_amt;
    logic [1:0] seen_state;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_value = '0;
    bus.sel_valid = 1'b0;  bus.sel_code = '0;
    bus.cancel = 1'b0;
    bus.restock_valid = 1'b0; bus.restock_code = '0;
    bus.clear_sales = 1'b0;
    bus.price_table = {8'd200, 8'd10, 8'd25, 8'd0};

    // coin_v coin sel_v sel cancel | credit rej disp code chg amt alarm total state
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   0, 0,  0, 0));
    vecs.push_back(mk(1, 10, 0, 0, 0,  10, 0, 0, 0, 0,   0, 0,  0, 1));
    vecs.push_back(mk(1, 10, 0, 0, 0,  20, 0, 0, 0, 0,   0, 0,  0, 1));
    vecs.push_back(mk(1, 10, 0, 0, 0,  30, 0, 0, 0, 0,   0, 0,  0, 1));
    vecs.push_back(mk(0,  0, 1, 1, 0,  30, 0, 1, 1, 0,   0, 0,  0, 2));
    vecs.push_back(mk(0,  0, 0, 0, 0,   5, 0, 0, 1, 1,   5, 0, 25, 3));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 1, 0,   5, 0, 25, 0));
    vecs.push_back(mk(1, 20, 0, 0, 0,  20, 0, 0, 1, 0,   5, 0, 25, 1));
    vecs.push_back(mk(0,  0, 1, 1, 0,  20, 0, 0, 1, 0,   5, 1, 25, 1));
    vecs.push_back(mk(1,  5, 0, 0, 0,  25, 0, 0, 1, 0,   5, 0, 25, 1));
    vecs.push_back(mk(0,  0, 1, 1, 0,  25, 0, 1, 1, 0,   5, 0, 25, 2));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 1, 0,   5, 0, 50, 3));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 1, 0,   5, 0, 50, 0));
    vecs.push_back(mk(1,200, 0, 0, 0, 200, 0, 0, 1, 0,   5, 0, 50, 1));
    vecs.push_back(mk(1, 50, 0, 0, 0, 250, 0, 0, 1, 0,   5, 0, 50, 1));
    vecs.push_back(mk(1, 10, 0, 0, 0, 250, 1, 0, 1, 0,   5, 0, 50, 1));
    vecs.push_back(mk(1,  5, 0, 0, 0, 255, 0, 0, 1, 0,   5, 0, 50, 1));
    vecs.push_back(mk(0,  0, 0, 0, 1, 255, 0, 0, 1, 1, 255, 0, 50, 3));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 1, 0, 255, 0, 50, 0));
    vecs.push_back(mk(1,  5, 0, 0, 0,   5, 0, 0, 1, 0, 255, 0, 50, 1));
    vecs.push_back(mk(0,  0, 1, 0, 0,   5, 0, 1, 0, 0, 255, 0, 50, 2));
    vecs.push_back(mk(0,  0, 0, 0, 0,   5, 0, 0, 0, 1,   5, 0, 50, 3));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   5, 0, 50, 0));
    vecs.push_back(mk(0,  0, 1, 1, 0,   0, 0, 0, 0, 0,   5, 1, 50, 0));
    vecs.push_back(mk(0,  0, 0, 0, 1,   0, 0, 0, 0, 0,   5, 1, 50, 0));
    vecs.push_back(mk(1,  5, 0, 0, 0,   5, 0, 0, 0, 0,   5, 0, 50, 1));
    vecs.push_back(mk(0,  0, 0, 0, 1,   5, 0, 0, 0, 1,   5, 0, 50, 3));
    vecs.push_back(mk(0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   5, 0, 50, 0));

    // Reset state, checked while reset is still asserted.
    #1;
    chk("reset credit", bus.credit, 0);
    chk("reset state", bus.state, 0);
    chk("reset alarm", bus.alarm, 0);
    chk("reset sales_total", bus.sales_total, 0);
    chk("reset pulses", {bus.coin_reject, bus.dispense_valid, bus.change_valid}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors: inputs applied for one cycle, registered outputs checked.
    foreach (vecs[i]) begin
      drive(vecs[i].coin_v, vecs[i].coin, vecs[i].sel_v, vecs[i].sel, vecs[i].cancel);
      chk($sformatf("v%0d credit", i), bus.credit, vecs[i].e_credit);
      chk($sformatf("v%0d coin_reject", i), bus.coin_reject, vecs[i].e_rej);
      chk($sformatf("v%0d dispense_valid", i), bus.dispense_valid, vecs[i].e_disp);
      chk($sformatf("v%0d dispense_code", i), bus.dispense_code, vecs[i].e_code);
      chk($sformatf("v%0d change_valid", i), bus.change_valid, vecs[i].e_chg);
      chk($sformatf("v%0d change_amount", i), bus.change_amount, vecs[i].e_amt);
      chk($sformatf("v%0d alarm", i), bus.alarm, vecs[i].e_alarm);
      chk($sformatf("v%0d sales_total", i), bus.sales_total, vecs[i].e_total);
      chk($sformatf("v%0d state", i), bus.state, vecs[i].e_state);
    end
    exp_total = 50;

    // Stock exhaustion on slot 2 (15 units), then restock and buy again.
    for (int n = 0; n < 15; n++) vend_ok(2'd2, 8'd10, $sformatf("stockA%0d", n));
    vend_sold_out(2'd2, 8'd10, "soldA");
    bus.restock_valid = 1'b1;
    bus.restock_code  = 2'd2;
    tick();
    bus.restock_valid = 1'b0;
    drive(1'b0, 8'd0, 1'b1, 2'd2, 1'b0);
    chk("restocked dispense_valid", bus.dispense_valid, 1);
    chk("restocked dispense_code", bus.dispense_code, 2);
    tick();
    exp_total = exp_total + 10;
    chk("restocked no change", bus.change_valid, 0);
    chk("restocked sales_total", bus.sales_total, exp_total);
    tick();
    chk("restocked idle", bus.state, 0);

    // Inactivity timeout: refund exactly TMO cycles after the credit update.
    drive(1'b1, 8'd10, 1'b0, 2'd0, 1'b0);
    chk("timeout credit", bus.credit, 10);
    seen = 0;
    seen_amt = '0;
    seen_state = '0;
    for (int i = 1; i <= TMO + 10; i++) begin
      tick();
      if (bus.change_valid && seen == 0) begin
        seen = i;
        seen_amt = bus.change_amount;
        seen_state = bus.state;
        break;
      end
    end
    chk("timeout latency", seen, TMO);
    chk("timeout change_amount", seen_amt, 10);
    chk("timeout state", seen_state, 3);
    tick();
    chk("timeout idle", bus.state, 0);

    // Cancel + select + coin in one COLLECT cycle: cancel wins, coin rejected.
    drive(1'b1, 8'd10, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'd5, 1'b1, 2'd1, 1'b1);
    chk("triple state", bus.state, 3);
    chk("triple change_valid", bus.change_valid, 1);
    chk("triple change_amount", bus.change_amount, 10);
    chk("triple coin_reject", bus.coin_reject, 1);
    chk("triple dispense_valid", bus.dispense_valid, 0);
    tick();
    chk("triple idle", bus.state, 0);

    // clear_sales and restock of the vending slot, both during VEND.
    drive(1'b1, 8'd10, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 2'd2, 1'b0);
    chk("clr vend state", bus.state, 2);
    bus.clear_sales   = 1'b1;
    bus.restock_valid = 1'b1;
    bus.restock_code  = 2'd2;
    tick();
    bus.clear_sales   = 1'b0;
    bus.restock_valid = 1'b0;
    chk("clr sales_total", bus.sales_total, 0);
    chk("clr state", bus.state, 3);
    tick();
    exp_total = 0;
    // Restock must have won over the decrement: 15 more units available.
    for (int n = 0; n < 15; n++) vend_ok(2'd2, 8'd10, $sformatf("stockB%0d", n));
    vend_sold_out(2'd2, 8'd10, "soldB");
    refund(8'd10, "soldB refund");

    // Asynchronous reset in the middle of VEND.
    drive(1'b1, 8'd25, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 2'd1, 1'b0);
    chk("rst pre state", bus.state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst state", bus.state, 0);
    chk("rst credit", bus.credit, 0);
    chk("rst dispense_valid", bus.dispense_valid, 0);
    chk("rst dispense_code", bus.dispense_code, 0);
    chk("rst change_amount", bus.change_amount, 0);
    chk("rst sales_total", bus.sales_total, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("rst no payout", bus.change_valid, 0);
    exp_total = 0;
    for (int n = 0; n < 15; n++) vend_ok(2'd2, 8'd10, $sformatf("stockC%0d", n));
    vend_sold_out(2'd2, 8'd10, "soldC");
    refund(8'd10, "soldC refund");
    chk("final sales_total", bus.sales_total, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
